// File: rtl/fs_nand_pkg.sv
// fs_nand_pkg: shared types and the arithmetic reference for the NAND subtractor slice
package fs_nand_pkg;
  typedef logic [1:0] fs_pair_t;
  function automatic fs_pair_t fs_ref(input logic a, input logic b, input logic bin);
    return fs_pair_t'({1'b0, a} - {1'b0, b} - {1'b0, bin});
  endfunction
endpackage

// File: rtl/fs_nand_if.sv
// fs_nand_if: operand, result and status signals of one subtractor slice
interface fs_nand_if;
  logic a;
  logic b;
  logic bin;
  logic diff;
  logic bout;
  logic diff_q;
  logic bout_q;
  logic valid_q;
  logic err_q;
  modport master(output a, b, bin, input diff, bout, diff_q, bout_q, valid_q, err_q);
  modport slave(input a, b, bin, output diff, bout, diff_q, bout_q, valid_q, err_q);
endinterface

// File: rtl/fs_nand_gate.sv
// nand2_gate: single 2-input NAND primitive
module nand2_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// File: rtl/fs_nand.sv
// fs_nand: 1-bit full subtractor from nine NAND2 gates with registered copy and sticky self-check
module fs_nand
  import fs_nand_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  fs_nand_if.slave    bus
);
  logic n1, n2, n3, x1, n4, n5, n6, d, bo;
  nand2_gate u_n1 (.a(bus.a),   .b(bus.b),   .y(n1));
  nand2_gate u_n2 (.a(bus.a),   .b(n1),      .y(n2));
  nand2_gate u_n3 (.a(bus.b),   .b(n1),      .y(n3));
  nand2_gate u_x1 (.a(n2),      .b(n3),      .y(x1));
  nand2_gate u_n4 (.a(x1),      .b(bus.bin), .y(n4));
  nand2_gate u_n5 (.a(x1),      .b(n4),      .y(n5));
  nand2_gate u_n6 (.a(bus.bin), .b(n4),      .y(n6));
  nand2_gate u_df (.a(n5),      .b(n6),      .y(d));
  nand2_gate u_bo (.a(n3),      .b(n6),      .y(bo));
  assign bus.diff = d;
  assign bus.bout = bo;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.diff_q  <= 1'b0;
      bus.bout_q  <= 1'b0;
      bus.valid_q <= 1'b0;
      bus.err_q   <= 1'b0;
    end else begin
      bus.diff_q  <= d;
      bus.bout_q  <= bo;
      bus.valid_q <= 1'b1;
      bus.err_q   <= bus.err_q | ({bo, d} !== fs_ref(bus.a, bus.b, bus.bin));
    end
  end
endmodule

// File: tb/tb_fs_nand.sv
// tb_fs_nand: randomized self-checking bench for fs_nand against an arithmetic model
module tb_fs_nand;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] tt;
  fs_nand_if bus();
  fs_nand_if r0();
  fs_nand_if r1();
  fs_nand_if r2();
  fs_nand_if r3();
  fs_nand dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fs_nand c0 (.clk(clk), .rst_n(rst_n), .bus(r0));
  fs_nand c1 (.clk(clk), .rst_n(rst_n), .bus(r1));
  fs_nand c2 (.clk(clk), .rst_n(rst_n), .bus(r2));
  fs_nand c3 (.clk(clk), .rst_n(rst_n), .bus(r3));
  assign r1.bin = r0.bout;
  assign r2.bin = r1.bout;
  assign r3.bin = r2.bout;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] model(input logic a, input logic b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return {r < 0, r[0]};
  endfunction
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] v);
    {bus.a, bus.b, bus.bin} = v;
  endtask
  initial begin
    logic [1:0] e;
    logic [3:0] ca, cb;
    logic [4:0] cr;
    tt = 16'b11_00_00_10_01_11_11_00;
    r0.bin = 1'b0;
    {r0.a, r1.a, r2.a, r3.a, r0.b, r1.b, r2.b, r3.b} = '0;
    drive(3'b000);
    for (int v = 0; v < 8; v++) begin
      drive(3'(v));
      #10;
      chk("tt_diff", 8'(bus.diff), 8'(tt[2*v+1]));
      chk("tt_bout", 8'(bus.bout), 8'(tt[2*v]));
      e = model(bus.a, bus.b, bus.bin);
      chk("tt_model", 8'({bus.bout, bus.diff}), 8'(e));
    end
    repeat (2) edge1();
    chk("rst_state", 8'({bus.diff_q, bus.bout_q, bus.valid_q, bus.err_q}), 8'h0);
    rst_n = 1'b1;
    drive(3'b100);
    edge1();
    chk("first_sample", 8'({bus.diff_q, bus.bout_q, bus.valid_q, bus.err_q}), 8'b1010);
    drive(3'b010);
    edge1();
    chk("pre_reset_q", 8'({bus.diff_q, bus.bout_q}), 8'b11);
    rst_n = 1'b0;
    edge1();
    chk("midrst_q", 8'({bus.diff_q, bus.bout_q, bus.valid_q, bus.err_q}), 8'h0);
    chk("midrst_comb", 8'({bus.diff, bus.bout}), 8'b11);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(3'($urandom_range(0, 7)));
      #1;
      e = model(bus.a, bus.b, bus.bin);
      chk("rnd_comb", 8'({bus.bout, bus.diff}), 8'(e));
      edge1();
      chk("rnd_q", 8'({bus.bout_q, bus.diff_q}), 8'(e));
      chk("rnd_stat", 8'({bus.valid_q, bus.err_q}), 8'b10);
    end
    drive(3'b000);
    #1;
    force dut.x1 = 1'b1;
    edge1();
    release dut.x1;
    chk("fault_err", 8'(bus.err_q), 8'h1);
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(0, 7)));
      edge1();
      chk("err_sticky", 8'(bus.err_q), 8'h1);
    end
    rst_n = 1'b0;
    edge1();
    chk("err_clear", 8'(bus.err_q), 8'h0);
    rst_n = 1'b1;
    ca = 4'b0101;
    cb = 4'b0110;
    for (int i = 0; i < 12; i++) begin
      {r3.a, r2.a, r1.a, r0.a} = ca;
      {r3.b, r2.b, r1.b, r0.b} = cb;
      #1;
      cr = {1'b0, ca} - {1'b0, cb};
      chk("chain_diff", 8'({r3.diff, r2.diff, r1.diff, r0.diff}), 8'(cr[3:0]));
      chk("chain_bout", 8'(r3.bout), 8'(cr[4]));
      ca = 4'($urandom_range(0, 15));
      cb = 4'($urandom_range(0, 15));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
